// File: rtl/stream_credit_pkg.sv
// rtl/stream_credit_pkg.sv - shared parameters and helpers for the credit-based stream link
package stream_credit_pkg;

  // Stage-count default shared by the transmitter and the receiver side
  localparam int DEFAULT_PIPE_STAGES = 2;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_RET  = 2'b01,
    CNT_PUSH = 2'b10,
    CNT_BOTH = 2'b11
  } cnt_op_e;

  function automatic int calc_cnt_width(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/stream_credit_pipe.sv
// rtl/stream_credit_pipe.sv - valid-qualified shift register with flush clear
module stream_credit_pipe #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic valid_i,
  input  T     data_i,
  output logic valid_o,
  output T     data_o
);

  if (DEPTH == 0) begin : g_bypass
    assign valid_o = valid_i;
    assign data_o  = data_i;
  end else begin : g_regs
    logic [DEPTH-1:0] valid_q;
    T                 data_q [DEPTH];
    logic [DEPTH-1:0] valid_in;
    T                 data_in [DEPTH];

    assign valid_in[0] = valid_i;
    assign data_in[0]  = data_i;
    for (genvar i = 1; i < DEPTH; i++) begin : g_chain
      assign valid_in[i] = valid_q[i-1];
      assign data_in[i]  = data_q[i-1];
    end

    // Data only moves with a valid beat, so idle stages keep their last payload
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          valid_q[i] <= valid_in[i] && !flush_i;
          if (valid_in[i]) begin
            data_q[i] <= data_in[i];
          end
        end
      end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];
  end

endmodule

// File: rtl/stream_credit_tx.sv
// rtl/stream_credit_tx.sv - credit-metered valid-only link transmitter
// Optional overflow detection: define STREAM_CREDIT_TX_ERR_EN.
module stream_credit_tx
  import stream_credit_pkg::*;
#(
  parameter int  DATA_WIDTH         = 32,
  parameter type T                  = logic [DATA_WIDTH-1:0],
  parameter int  CREDITS            = 8,
  parameter int  PIPE_STAGES        = DEFAULT_PIPE_STAGES,
  parameter int  CREDIT_PIPE_STAGES = DEFAULT_PIPE_STAGES,
  parameter int  CNT_WIDTH          = calc_cnt_width(CREDITS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  T                     data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output T                     data_o,
  output logic                 valid_o,
  input  logic                 credit_i,
  output logic [CNT_WIDTH-1:0] credits_o,
  output logic                 err_o
);

  localparam logic [CNT_WIDTH-1:0] CREDITS_C = CNT_WIDTH'(CREDITS);

  logic                 push;
  logic                 ret;
  logic                 credit_valid;
  logic                 credit_data;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  cnt_op_e              op;

  assign ready_o = (cnt_q != '0) && !flush_i;
  assign push    = valid_i && ready_o;

  stream_credit_pipe #(
    .DEPTH (PIPE_STAGES),
    .T     (T)
  ) u_fwd_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .valid_i (push),
    .data_i  (data_i),
    .valid_o (valid_o),
    .data_o  (data_o)
  );

  // The credit payload is a constant 1; the pulse is the valid bit
  stream_credit_pipe #(
    .DEPTH (CREDIT_PIPE_STAGES),
    .T     (logic)
  ) u_credit_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .valid_i (credit_i),
    .data_i  (1'b1),
    .valid_o (credit_valid),
    .data_o  (credit_data)
  );

  assign ret = credit_valid && credit_data;
  assign op  = cnt_op_e'({push, ret});

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = CREDITS_C;
    end else begin
      case (op)
        CNT_PUSH: cnt_d = cnt_q - 1'b1;
        CNT_RET:  if (cnt_q != CREDITS_C) cnt_d = cnt_q + 1'b1;
        default:  cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= CREDITS_C;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign credits_o = cnt_q;

`ifdef STREAM_CREDIT_TX_ERR_EN
  logic overflow;
  logic err_q;

  // A credit returned with the counter already full means the receiver miscounted
  assign overflow = (op == CNT_RET) && (cnt_q == CREDITS_C) && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (overflow) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  credit_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !overflow);
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_stream_credit_tx.sv
// tb/tb_stream_credit_tx.sv - directed self-checking bench for stream_credit_tx
module tb_stream_credit_tx;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready;
  logic [31:0] data_out;
  logic        valid_out;
  logic        credit;
  logic [3:0]  credits;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  stream_credit_tx #(
    .DATA_WIDTH         (32),
    .CREDITS            (8),
    .PIPE_STAGES        (2),
    .CREDIT_PIPE_STAGES (2)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .flush_i   (flush),
    .data_i    (data_in),
    .valid_i   (valid_in),
    .ready_o   (ready),
    .data_o    (data_out),
    .valid_o   (valid_out),
    .credit_i  (credit),
    .credits_o (credits),
    .err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; data_in = '0; credit = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (credits !== 4'd8) begin n_fail++; $display("FAIL reset_credits got %0d want 8", credits); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_out); end
    n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", data_out); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    for (int c = 0; c < 12; c++) begin
      valid_in = (c < 8);
      data_in  = 32'h11 + c;
      @(negedge clk);
      n_checks++;
      if (ready !== 1'(c < 8)) begin n_fail++; $display("FAIL stream_ready c=%0d got %b want %b", c, ready, c < 8); end
      n_checks++;
      if (credits !== 4'((c <= 8) ? 8 - c : 0)) begin n_fail++; $display("FAIL stream_credits c=%0d got %0d want %0d", c, credits, (c <= 8) ? 8 - c : 0); end
      n_checks++;
      if (valid_out !== 1'(c >= 2 && c < 10)) begin n_fail++; $display("FAIL stream_valid c=%0d got %b want %b", c, valid_out, c >= 2 && c < 10); end
      if (c >= 2 && c < 10) begin
        n_checks++;
        if (data_out !== 32'h11 + c - 2) begin n_fail++; $display("FAIL stream_data c=%0d got %h want %h", c, data_out, 32'h11 + c - 2); end
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
  endtask

  task automatic test_credit_return();
    for (int c = 0; c < 6; c++) begin
      credit   = (c == 0);
      valid_in = (c == 3);
      data_in  = 32'h21;
      @(negedge clk);
      n_checks++;
      if (credits !== 4'((c == 3) ? 1 : 0)) begin n_fail++; $display("FAIL ret_credits c=%0d got %0d want %0d", c, credits, (c == 3) ? 1 : 0); end
      n_checks++;
      if (ready !== 1'(c == 3)) begin n_fail++; $display("FAIL ret_ready c=%0d got %b want %b", c, ready, c == 3); end
      n_checks++;
      if (valid_out !== 1'(c == 5)) begin n_fail++; $display("FAIL ret_valid c=%0d got %b want %b", c, valid_out, c == 5); end
      if (c == 5) begin
        n_checks++;
        if (data_out !== 32'h21) begin n_fail++; $display("FAIL ret_data got %h want 21", data_out); end
      end
      @(posedge clk); #1;
    end
    credit = 1'b0; valid_in = 1'b0;
  endtask

  task automatic test_push_and_ret();
    int exp_cr;
    for (int c = 0; c < 8; c++) begin
      credit   = (c < 4);
      valid_in = (c == 5);
      data_in  = 32'h31;
      exp_cr   = (c < 3) ? 0 : (c == 3) ? 1 : (c == 4) ? 2 : 3;
      @(negedge clk);
      n_checks++;
      if (credits !== 4'(exp_cr)) begin n_fail++; $display("FAIL both_credits c=%0d got %0d want %0d", c, credits, exp_cr); end
      n_checks++;
      if (ready !== 1'(exp_cr != 0)) begin n_fail++; $display("FAIL both_ready c=%0d got %b want %b", c, ready, exp_cr != 0); end
      n_checks++;
      if (valid_out !== 1'(c == 7)) begin n_fail++; $display("FAIL both_valid c=%0d got %b want %b", c, valid_out, c == 7); end
      if (c == 7) begin
        n_checks++;
        if (data_out !== 32'h31) begin n_fail++; $display("FAIL both_data got %h want 31", data_out); end
      end
      @(posedge clk); #1;
    end
    credit = 1'b0; valid_in = 1'b0;
  endtask

  task automatic test_flush();
    int exp_cr;
    for (int c = 0; c < 12; c++) begin
      credit   = (c < 3);
      valid_in = (c == 6 || c == 7);
      data_in  = 32'h41 + c - 6;
      flush    = (c == 8);
      case (c)
        0, 1, 2: exp_cr = 3;
        3:       exp_cr = 4;
        4:       exp_cr = 5;
        5, 6:    exp_cr = 6;
        7:       exp_cr = 5;
        8:       exp_cr = 4;
        default: exp_cr = 8;
      endcase
      @(negedge clk);
      n_checks++;
      if (credits !== 4'(exp_cr)) begin n_fail++; $display("FAIL flush_credits c=%0d got %0d want %0d", c, credits, exp_cr); end
      n_checks++;
      if (ready !== 1'(c != 8)) begin n_fail++; $display("FAIL flush_ready c=%0d got %b want %b", c, ready, c != 8); end
      n_checks++;
      if (valid_out !== 1'(c == 8)) begin n_fail++; $display("FAIL flush_valid c=%0d got %b want %b", c, valid_out, c == 8); end
      if (c == 8) begin
        n_checks++;
        if (data_out !== 32'h41) begin n_fail++; $display("FAIL flush_data got %h want 41", data_out); end
      end
      @(posedge clk); #1;
    end
    credit = 1'b0; valid_in = 1'b0; flush = 1'b0;
  endtask

  task automatic test_overflow();
    logic exp_err;
    for (int c = 0; c < 6; c++) begin
      credit = (c == 0);
`ifdef STREAM_CREDIT_TX_ERR_EN
      exp_err = (c >= 3);
`else
      exp_err = 1'b0;
`endif
      @(negedge clk);
      n_checks++;
      if (credits !== 4'd8) begin n_fail++; $display("FAIL ovf_credits c=%0d got %0d want 8", c, credits); end
      n_checks++;
      if (err !== exp_err) begin n_fail++; $display("FAIL ovf_err c=%0d got %b want %b", c, err, exp_err); end
      @(posedge clk); #1;
    end
    credit = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      valid_in = 1'b1;
      data_in  = 32'h51 + c;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    @(negedge clk);
    n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL mid_valid_pre got %b want 1", valid_out); end
    n_checks++; if (credits !== 4'd6) begin n_fail++; $display("FAIL mid_credits_pre got %0d want 6", credits); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_valid_rst got %b want 0", valid_out); end
    n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL mid_data_rst got %h want 0", data_out); end
    n_checks++; if (credits !== 4'd8) begin n_fail++; $display("FAIL mid_credits_rst got %0d want 8", credits); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_err_rst got %b want 0", err); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_valid_post got %b want 0", valid_out); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_post got %b want 1", ready); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_credit_return();
    test_push_and_ret();
    test_flush();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_credit_tx.md
# stream_credit_tx

Credit-based transmitter feeding a spatially distributed `stream_fifo_segmented` over a long, retimed link. It converts a local valid/ready stream into a valid-only forward path with PIPE_STAGES register stages. It meters each beat against a credit counter sized to the remote FIFO depth, so no back-pressure wire has to cross the link. The receiver returns one credit pulse per beat popped from its FIFO; the credit pulse travels back through CREDIT_PIPE_STAGES registers.

## Interface
- DATA_WIDTH, 32: width of the default payload type.
- T, logic [DATA_WIDTH-1:0]: payload type.
- CREDITS, 8: initial and maximum credit count. Must equal the downstream FIFO DEPTH and be ≥ 1.
- PIPE_STAGES, 2: forward register stages on valid_o/data_o. 0 means combinational pass-through.
- CREDIT_PIPE_STAGES, 2: register stages on the returned credit pulse. 0 means direct.
- CNT_WIDTH, $clog2(CREDITS+1): derived; do not override.

Ports:
- clk_i  in  1  clock; everything is rising-edge.
- rst_ni  in  1  asynchronous reset, active-low.
- flush_i  in  1  synchronous flush. Asserted in the same cycle as the downstream FIFO flush.
- data_i  in  T  payload.
- valid_i  in  1  payload valid.
- ready_o  out  1  beat accepted when valid_i && ready_o.
- data_o  out  T  link payload.
- valid_o  out  1  link beat. The receiver must accept it; there is no ready.
- credit_i  in  1  one-cycle pulse per beat popped at the receiver.
- credits_o  out  CNT_WIDTH  current credit count.
- err_o  out  1  sticky credit-overflow error; see Configuration.

## Operation
- Credit counter `cnt`:
  - Resets to CREDITS.
  - ready_o = (cnt != 0) && !flush_i.
- Per-cycle update, with `push` = valid_i && ready_o and `ret` = the credit pulse at the output of the credit pipe:
  - push only: cnt−1.
  - ret only: cnt+1.
  - Both in the same cycle: cnt unchanged.
  - Neither: unchanged.
- A push at cnt == 1 together with ret keeps ready_o high on the next cycle.
- Overflow: if ret arrives while cnt == CREDITS and there is no push, cnt saturates at CREDITS and the error flag sets. Arithmetic is unsigned CNT_WIDTH and never wraps.
- Forward pipe: a shift register of {valid, data} with PIPE_STAGES entries.
  - Stage 0 loads {push, data_i}.
  - Data registers load only when the incoming valid is 1, so they hold their value otherwise.
  - valid_o = last stage valid. data_o = last stage data.
- Credit pipe: a CREDIT_PIPE_STAGES-deep shift register of credit_i. Its last stage is ret.
- flush_i, in the cycle it is high:
  - ready_o = 0.
  - All forward and credit pipe valid bits are cleared on the next edge.
  - cnt is reloaded to CREDITS.
  - The error flag is kept.
  - In-flight beats and credits are discarded, matching the receiver FIFO flush.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). In-flight beats are lost.

## Timing
- Reset values:
  - valid_o = 0; data_o = '0.
  - ready_o = 1 once rst_ni is high and flush_i is low.
  - credits_o = CREDITS; err_o = 0.
- Forward latency: a beat accepted in cycle t appears on valid_o in cycle t+PIPE_STAGES.
- Credit latency: credit_i high in cycle t increments credits_o at cycle t+CREDIT_PIPE_STAGES+1.
- Throughput: one beat per cycle while credits remain. A round trip shorter than CREDITS cycles sustains full rate.
- credits_o and err_o are registered. ready_o is combinational from cnt and flush_i only, never from valid_i.

## Configuration
- `STREAM_CREDIT_TX_ERR_EN` defined:
  - Overflow detection is compiled in; err_o sets on overflow and clears only on reset.
  - A simulation assertion also fires on the same condition.
- Undefined: err_o is tied to 0 and the detection logic is absent. Saturation of cnt is unchanged.

## Structure
- Package `stream_credit_pkg` holds:
  - the function computing CNT_WIDTH from CREDITS;
  - the localparam default for stage counts, shared with the future `stream_credit_rx`.
- Sub-module `stream_credit_pipe`: a parameterised valid-qualified shift register (DEPTH, T, flush clear).
  - Instantiated once for the forward path with T.
  - Instantiated once for the credit path with a 1-bit payload and valid used as the pulse.

## Test plan
- Reset release, CREDITS=8, PIPE_STAGES=2 → credits_o=8, ready_o=1, valid_o=0.
- Stream 8 beats (0x11..0x18) back-to-back with no credits returned:
  - valid_o shows 0x11..0x18 in cycles 2..9;
  - credits_o reaches 0 and ready_o drops after the 8th beat.
- At cnt=0, pulse credit_i once (CREDIT_PIPE_STAGES=2) → credits_o=1 three cycles later; the next beat is accepted and credits_o returns to 0.
- Push and ret in the same cycle at cnt=3 → credits_o stays 3 and ready_o stays 1.
- Flush with 2 beats in flight and cnt=4 → valid_o stays 0 afterwards and credits_o=8 next cycle.
- Macro defined, credit_i pulsed at cnt=8 → credits_o stays 8 and err_o=1 sticky until reset. With the macro undefined, err_o stays 0.
